// File: rtl/topk_heap.sv
// topk_heap: keeps the CAP highest-count {cnt,addr} entries as a register-array min-heap.
// Define TOPK_HEAP_DROP_CNT_EN to add the saturating drop_cnt output.
module topk_heap #(
    parameter int CNT_SIZE    = 20,
    parameter int ADDR_SIZE   = 28,
    parameter int TOTAL_LEVEL = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [CNT_SIZE-1:0]    input_cnt,
    input  logic [ADDR_SIZE-1:0]   input_addr,
    input  logic                   query_valid,
    output logic                   query_ready,
    output logic                   query_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNT_SIZE-1:0]    out_cnt,
    output logic [ADDR_SIZE-1:0]   out_addr,
    output logic                   out_last,
    output logic [TOTAL_LEVEL-1:0] size,
    output logic                   full,
`ifdef TOPK_HEAP_DROP_CNT_EN
    output logic [31:0]            drop_cnt,
`endif
    output logic [CNT_SIZE-1:0]    min_cnt
);

    localparam int CAP = (1 << TOTAL_LEVEL) - 1;
    localparam int IW  = TOTAL_LEVEL + 1;

    typedef logic [TOTAL_LEVEL-1:0] idx_t;
    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN, DRAIN} state_t;

    state_t state, state_n;
    idx_t   ptr;

    logic [CNT_SIZE-1:0]  heap_cnt  [CAP];
    logic [ADDR_SIZE-1:0] heap_addr [CAP];

    idx_t          parent, last_idx, lc, rc, sel;
    logic [IW-1:0] lc_w, rc_w;
    logic          lc_ok, rc_ok, up_stop, dn_swap;
    logic          ins_acc, qry_acc, keep, beat;

    assign parent   = (ptr - idx_t'(1)) >> 1;
    assign last_idx = size - idx_t'(1);
    assign lc_w     = {ptr, 1'b1};
    assign rc_w     = lc_w + IW'(1);
    assign lc_ok    = lc_w < {1'b0, size};
    assign rc_ok    = rc_w < {1'b0, size};
    assign lc       = lc_w[TOTAL_LEVEL-1:0];
    assign rc       = rc_w[TOTAL_LEVEL-1:0];

    // Left child wins ties; an absent right child is never selected.
    assign sel     = (rc_ok && heap_cnt[rc] < heap_cnt[lc]) ? rc : lc;
    assign dn_swap = lc_ok && (heap_cnt[sel] < heap_cnt[ptr]);
    assign up_stop = (ptr == '0) || (heap_cnt[parent] <= heap_cnt[ptr]);

    assign full        = (size == idx_t'(CAP));
    assign min_cnt     = (size == '0) ? '0 : heap_cnt[0];
    assign input_ready = (state == IDLE) && !query_valid;
    assign query_ready = (state == IDLE);
    assign ins_acc     = input_valid && input_ready;
    assign qry_acc     = query_valid && query_ready;
    assign keep        = input_cnt > min_cnt;

    assign out_valid = (state == DRAIN);
    assign out_cnt   = out_valid ? heap_cnt[ptr] : '0;
    assign out_addr  = out_valid ? heap_addr[ptr] : '0;
    assign out_last  = out_valid && (ptr == last_idx);
    assign beat      = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (qry_acc) begin
                    if (size != '0) state_n = DRAIN;
                end else if (ins_acc) begin
                    if (!full) state_n = SIFT_UP;
                    else if (keep) state_n = SIFT_DOWN;
                end
            end
            SIFT_UP:   if (up_stop) state_n = IDLE;
            SIFT_DOWN: if (!dn_swap) state_n = IDLE;
            DRAIN:     if (beat && out_last) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size       <= '0;
            ptr        <= '0;
            query_done <= 1'b0;
        end else begin
            query_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (qry_acc) begin
                        ptr <= '0;
                        if (size == '0) query_done <= 1'b1;
                    end else if (ins_acc && !full) begin
                        size <= size + idx_t'(1);
                        ptr  <= size;
                    end else if (ins_acc && keep) begin
                        ptr <= '0;
                    end
                end
                SIFT_UP:   if (!up_stop) ptr <= parent;
                SIFT_DOWN: if (dn_swap) ptr <= sel;
                DRAIN: begin
                    if (beat) begin
                        if (out_last) begin
                            size       <= '0;
                            ptr        <= '0;
                            query_done <= 1'b1;
                        end else begin
                            ptr <= ptr + idx_t'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Heap storage carries no reset: contents beyond size are never observed.
    always_ff @(posedge clk) begin
        unique case (state)
            IDLE: begin
                if (ins_acc && !full) begin
                    heap_cnt[size]  <= input_cnt;
                    heap_addr[size] <= input_addr;
                end else if (ins_acc && keep) begin
                    heap_cnt[0]  <= input_cnt;
                    heap_addr[0] <= input_addr;
                end
            end
            SIFT_UP: begin
                if (!up_stop) begin
                    heap_cnt[ptr]     <= heap_cnt[parent];
                    heap_addr[ptr]    <= heap_addr[parent];
                    heap_cnt[parent]  <= heap_cnt[ptr];
                    heap_addr[parent] <= heap_addr[ptr];
                end
            end
            SIFT_DOWN: begin
                if (dn_swap) begin
                    heap_cnt[ptr]  <= heap_cnt[sel];
                    heap_addr[ptr] <= heap_addr[sel];
                    heap_cnt[sel]  <= heap_cnt[ptr];
                    heap_addr[sel] <= heap_addr[ptr];
                end
            end
            default: ;
        endcase
    end

`ifdef TOPK_HEAP_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (ins_acc && full && !keep && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_topk_heap.sv
// tb_topk_heap: randomized scoreboard bench for topk_heap against a top-K multiset model.
// A second small instance (TOTAL_LEVEL=2) covers full/drop/reset-in-sift corners.
module tb_topk_heap;

    localparam int CW   = 20;
    localparam int AW   = 28;
    localparam int LA   = 6;
    localparam int CAPA = 63;
    localparam int LB   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic          a_rst_n, a_in_valid, a_q_valid;
    logic [CW-1:0] a_in_cnt;
    logic [AW-1:0] a_in_addr;
    logic          a_in_ready, a_q_ready, a_query_done;
    logic          a_out_valid, a_out_last, a_full;
    logic          a_out_ready = 1'b1;
    logic [CW-1:0] a_out_cnt, a_min;
    logic [AW-1:0] a_out_addr;
    logic [LA-1:0] a_size;

    logic          b_rst_n, b_in_valid, b_q_valid;
    logic [CW-1:0] b_in_cnt;
    logic [AW-1:0] b_in_addr;
    logic          b_in_ready, b_q_ready, b_query_done;
    logic          b_out_valid, b_out_last, b_full;
    logic          b_out_ready = 1'b1;
    logic [CW-1:0] b_out_cnt, b_min;
    logic [AW-1:0] b_out_addr;
    logic [LB-1:0] b_size;
`ifdef TOPK_HEAP_DROP_CNT_EN
    logic [31:0]   a_drop, b_drop;
`endif

    topk_heap #(.CNT_SIZE(CW), .ADDR_SIZE(AW), .TOTAL_LEVEL(LA)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .input_valid(a_in_valid), .input_ready(a_in_ready),
        .input_cnt(a_in_cnt), .input_addr(a_in_addr),
        .query_valid(a_q_valid), .query_ready(a_q_ready),
        .query_done(a_query_done),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_cnt(a_out_cnt), .out_addr(a_out_addr), .out_last(a_out_last),
        .size(a_size), .full(a_full),
`ifdef TOPK_HEAP_DROP_CNT_EN
        .drop_cnt(a_drop),
`endif
        .min_cnt(a_min)
    );

    topk_heap #(.CNT_SIZE(CW), .ADDR_SIZE(AW), .TOTAL_LEVEL(LB)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .input_valid(b_in_valid), .input_ready(b_in_ready),
        .input_cnt(b_in_cnt), .input_addr(b_in_addr),
        .query_valid(b_q_valid), .query_ready(b_q_ready),
        .query_done(b_query_done),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_cnt(b_out_cnt), .out_addr(b_out_addr), .out_last(b_out_last),
        .size(b_size), .full(b_full),
`ifdef TOPK_HEAP_DROP_CNT_EN
        .drop_cnt(b_drop),
`endif
        .min_cnt(b_min)
    );

    task automatic chk(input bit ok, input string nm, input longint got, input longint exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Address is a fixed function of the count, so equal-count entries are interchangeable.
    function automatic logic [AW-1:0] faddr(input int unsigned c);
        return AW'(c + 100);
    endfunction

    // Reference model: multiset of the CAPA largest counts seen since the last drain.
    int unsigned mdl[$];
    int unsigned a_drops = 0;

    function automatic int unsigned mdl_min();
        int unsigned m;
        if (mdl.size() == 0) return 0;
        m = mdl[0];
        foreach (mdl[i]) if (mdl[i] < m) m = mdl[i];
        return m;
    endfunction

    task automatic mdl_insert(input int unsigned c);
        int mi;
        if (mdl.size() < CAPA) begin
            mdl.push_back(c);
        end else begin
            mi = 0;
            foreach (mdl[i]) if (mdl[i] < mdl[mi]) mi = i;
            if (c > mdl[mi]) mdl[mi] = c;
            else a_drops++;
        end
    endtask

    // Scoreboard: one length entry per expected drain, counts flattened and sorted.
    int unsigned exp_len[$];
    int unsigned exp_cnt[$];

    task automatic push_expected();
        int unsigned t[$];
        t = mdl;
        t.sort();
        exp_len.push_back(t.size());
        foreach (t[i]) exp_cnt.push_back(t[i]);
    endtask

    int          drains_done = 0;
    int          total_beats = 0;
    int          rdy_mode = 0;
    int          stall_at = -1;
    int          stall_left = 0;

    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            a_out_ready = 1'b0;
            stall_left--;
        end else if (stall_at >= 0 && total_beats >= stall_at) begin
            a_out_ready = 1'b0;
            stall_left = 3;
            stall_at = -1;
        end else if (rdy_mode == 1) begin
            a_out_ready = ($urandom % 3) != 0;
        end else begin
            a_out_ready = 1'b1;
        end
    end

    int unsigned   cur[$];
    int unsigned   m_e[$];
    int unsigned   m_g[$];
    int unsigned   m_n;
    bit            m_ok;
    bit            exp_done = 1'b0;
    bit            held = 1'b0;
    logic [CW-1:0] h_cnt;
    logic [AW-1:0] h_addr;
    logic          h_last;

    always @(negedge clk) begin
        if (a_rst_n) begin
            if (exp_done) begin
                chk(a_query_done && !a_out_valid && a_size == 0, "drain_done",
                    a_query_done, 1);
                exp_done = 1'b0;
            end
            if (held) begin
                chk(a_out_valid && a_out_cnt == h_cnt && a_out_addr == h_addr
                    && a_out_last == h_last, "hold_stable", a_out_cnt, h_cnt);
            end
            held = a_out_valid && !a_out_ready;
            h_cnt = a_out_cnt;
            h_addr = a_out_addr;
            h_last = a_out_last;
            if (a_out_valid && a_out_ready) begin
                total_beats++;
                if (exp_len.size() == 0) begin
                    chk(1'b0, "unexpected_beat", a_out_cnt, 0);
                end else begin
                    chk(a_out_addr == faddr(a_out_cnt), "beat_addr",
                        a_out_addr, faddr(a_out_cnt));
                    cur.push_back(int'(a_out_cnt));
                    if (a_out_last) begin
                        m_n = exp_len.pop_front();
                        m_e.delete();
                        for (int i = 0; i < int'(m_n); i++) m_e.push_back(exp_cnt.pop_front());
                        chk(cur.size() == m_n, "drain_len", cur.size(), m_n);
                        m_g = cur;
                        m_g.sort();
                        m_ok = (m_g.size() == m_e.size());
                        if (m_ok) foreach (m_g[i]) if (m_g[i] != m_e[i]) m_ok = 1'b0;
                        chk(m_ok, "drain_set", m_g[0], m_e[0]);
                        m_ok = 1'b1;
                        for (int i = 1; i < cur.size(); i++)
                            if (cur[(i-1)/2] > cur[i]) m_ok = 1'b0;
                        chk(m_ok, "drain_heap_order", cur[0], m_e[0]);
                        chk(cur[0] == m_e[0], "drain_first_min", cur[0], m_e[0]);
                        cur.delete();
                        exp_done = 1'b1;
                        drains_done++;
                    end
                end
            end
        end
    end

    task automatic a_finish_insert(input int unsigned c);
        int k;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        mdl_insert(c);
        k = 0;
        do begin @(negedge clk); k++; end while (!a_in_ready && k < 50);
        chk(a_in_ready && k <= LA + 1, "ins_latency", k, LA + 1);
        chk(a_size == mdl.size(), "size", a_size, mdl.size());
        chk(a_min == mdl_min(), "min_cnt", a_min, mdl_min());
        chk(a_full == (mdl.size() == CAPA), "full", a_full, mdl.size() == CAPA);
    endtask

    task automatic a_insert(input int unsigned c);
        int k;
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_in_cnt = CW'(c);
        a_in_addr = faddr(c);
        k = 0;
        do begin @(negedge clk); k++; end while (!a_in_ready && k < 200);
        chk(a_in_ready, "ins_accept", k, 0);
        a_finish_insert(c);
    endtask

    task automatic a_query();
        int k, d0;
        bit empty;
        @(posedge clk); #1;
        a_q_valid = 1'b1;
        @(negedge clk);
        chk(a_q_ready, "query_ready", a_q_ready, 1);
        d0 = drains_done;
        empty = (mdl.size() == 0);
        if (!empty) push_expected();
        @(posedge clk); #1;
        a_q_valid = 1'b0;
        if (empty) begin
            @(negedge clk);
            chk(a_query_done && !a_out_valid, "empty_done", a_query_done, 1);
            @(negedge clk);
            chk(!a_query_done && !a_out_valid, "empty_done_pulse", a_query_done, 0);
        end else begin
            k = 0;
            while (drains_done == d0 && k < 5000) begin @(negedge clk); k++; end
            chk(drains_done != d0, "drain_timeout", k, 5000);
        end
        mdl.delete();
    endtask

    task automatic a_both(input int unsigned c);
        int k, d0;
        @(posedge clk); #1;
        a_q_valid = 1'b1;
        a_in_valid = 1'b1;
        a_in_cnt = CW'(c);
        a_in_addr = faddr(c);
        @(negedge clk);
        chk(!a_in_ready, "both_insert_held", a_in_ready, 0);
        chk(a_q_ready, "both_query_ready", a_q_ready, 1);
        d0 = drains_done;
        push_expected();
        @(posedge clk); #1;
        a_q_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!a_in_ready && k < 5000);
        chk(drains_done == d0 + 1, "insert_after_drain", drains_done - d0, 1);
        mdl.delete();
        a_finish_insert(c);
    endtask

    task automatic b_insert(input int unsigned c);
        int k;
        @(posedge clk); #1;
        b_in_valid = 1'b1;
        b_in_cnt = CW'(c);
        b_in_addr = faddr(c);
        k = 0;
        do begin @(negedge clk); k++; end while (!b_in_ready && k < 50);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        k = 0;
        do begin @(negedge clk); k++; end while (!b_in_ready && k < 50);
        chk(b_in_ready, "b_idle", k, 0);
    endtask

    task automatic b_part();
        int unsigned got[$];
        int k;
        bit last;
        b_insert(7); b_insert(6); b_insert(11);
        chk(b_full && b_min == 6 && b_size == 3, "b_full_min6", b_min, 6);
        b_insert(5);
        chk(b_min == 6 && b_size == 3, "b_drop_min", b_min, 6);
`ifdef TOPK_HEAP_DROP_CNT_EN
        chk(b_drop == 1, "b_drop_cnt", b_drop, 1);
`endif
        b_insert(8);
        chk(b_min == 7 && b_full, "b_replace_min7", b_min, 7);
        @(posedge clk); #1;
        b_q_valid = 1'b1;
        @(posedge clk); #1;
        b_q_valid = 1'b0;
        k = 0;
        last = 1'b0;
        while (!last && k < 50) begin
            @(negedge clk);
            k++;
            if (b_out_valid && b_out_ready) begin
                got.push_back(int'(b_out_cnt));
                chk(b_out_addr == faddr(b_out_cnt), "b_beat_addr", b_out_addr, faddr(b_out_cnt));
                last = b_out_last;
            end
        end
        chk(last, "b_drain_last", k, 50);
        got.sort();
        chk(got.size() == 3 && got[0] == 7 && got[1] == 8 && got[2] == 11,
            "b_drain_set", got.size(), 3);
        @(negedge clk);
        chk(b_query_done && b_size == 0, "b_drain_done", b_query_done, 1);
        b_insert(7); b_insert(8); b_insert(11);
        @(posedge clk); #1;
        b_in_valid = 1'b1;
        b_in_cnt = CW'(28);
        b_in_addr = faddr(28);
        @(negedge clk);
        chk(b_in_ready, "b_accept_28", b_in_ready, 1);
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_rst_n = 1'b0;
        #1;
        chk(b_size == 0 && b_min == 0 && !b_full && !b_out_valid,
            "b_reset_mid_sift", b_size, 0);
        @(negedge clk);
        b_rst_n = 1'b1;
        @(negedge clk);
        chk(b_in_ready, "b_ready_after_reset", b_in_ready, 1);
        b_insert(5);
        chk(b_size == 1 && b_min == 5, "b_first_after_reset", b_min, 5);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_in_valid = 1'b0; a_q_valid = 1'b0; a_in_cnt = '0; a_in_addr = '0;
        b_in_valid = 1'b0; b_q_valid = 1'b0; b_in_cnt = '0; b_in_addr = '0;
        repeat (3) @(negedge clk);
        chk(a_size == 0 && !a_full && a_min == 0, "reset_size", a_size, 0);
        chk(!a_out_valid && !a_out_last && !a_query_done && a_out_cnt == 0
            && a_out_addr == 0, "reset_outputs", a_out_valid, 0);
`ifdef TOPK_HEAP_DROP_CNT_EN
        chk(a_drop == 0, "reset_drop_cnt", a_drop, 0);
`endif
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        chk(a_in_ready && a_q_ready, "ready_after_reset", a_in_ready, 1);

        a_query();

        a_insert(7); a_insert(6); a_insert(11); a_insert(5); a_insert(8); a_insert(3);
        chk(a_size == 6 && a_min == 3, "seq_size6_min3", a_min, 3);
        a_query();

        a_insert(20); a_insert(10); a_insert(30);
        stall_at = total_beats + 1;
        a_query();

        a_insert(40); a_insert(41);
        a_both(55);

        rdy_mode = 1;
        repeat (90) a_insert($urandom_range(0, 80));
        for (int i = 0; i < 220; i++) begin
            if ($urandom % 120 == 0) begin
                a_query();
            end else begin
                c = ($urandom % 4 == 0) ? ($urandom & 32'hFFFFF) : $urandom_range(0, 80);
                a_insert(c);
            end
        end
`ifdef TOPK_HEAP_DROP_CNT_EN
        chk(a_drop == a_drops, "drop_cnt_total", a_drop, a_drops);
`endif
        a_query();
        rdy_mode = 0;

        b_part();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
